branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  EX-stage producer of the redirect request consumed by the branch/flush unit.
//  Evaluates RV32 conditional branches, JAL and JALR, and computes the target.
//  Issues a registered one-cycle 'branch' pulse with 'branch_target', then blanks
//  resolution for the wrong-path shadow while IF/ID are being flushed.
//  Also keeps a saturating redirect counter for performance statistics.
// PARAMETERS
//  XLEN           32  datapath / address width
//  SHADOW_CYCLES  1   post-redirect cycles in which ex_valid is ignored (>=1)
//  CNT_W          16  width of redirect_count
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     asynchronous active-low reset
//  ex_valid       in   1     instruction in EX is valid
//  ex_stall       in   1     EX stage held this cycle
//  is_branch      in   1     EX instruction is a conditional branch
//  is_jal         in   1     EX instruction is JAL
//  is_jalr        in   1     EX instruction is JALR
//  funct3         in   3     branch condition select
//  rs1_data       in   XLEN  forwarded operand 1
//  rs2_data       in   XLEN  forwarded operand 2
//  pc             in   XLEN  PC of EX instruction
//  imm            in   XLEN  sign-extended immediate
//  branch         out  1     redirect pulse to branch/flush unit
//  branch_target  out  XLEN  redirect address, valid while branch=1
//  busy           out  1     1 in REDIRECT/SHADOW (resolution blanked)
//  illegal_br     out  1     1-cycle pulse: is_branch with funct3 010/011
//  redirect_count out  CNT_W saturating count of issued redirects
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; branch=0, branch_target=0, busy=0,
//   illegal_br=0, redirect_count=0, shadow counter=0. Reset mid-redirect aborts it.
//  Resolve condition (cycle N): state=IDLE & ex_valid & !ex_stall.
//  Priority: is_jalr > is_jal > is_branch; none set -> no action.
//  Taken: jal/jalr always; branch per funct3: 000 EQ, 001 NE, 100 LT signed,
//   101 GE signed, 110 LTU, 111 GEU. Funct3 010/011 -> not taken, illegal_br=1 at N+1.
//  Target: branch/jal = pc+imm; jalr = (rs1_data+imm) & ~1. Mod 2^XLEN, wrap silent.
//  Latency 1: taken at N -> branch=1, branch_target valid, state=REDIRECT in N+1.
//  FSM:
//   IDLE     -> REDIRECT when resolve & taken; else stay.
//   REDIRECT -> SHADOW unconditionally; branch=1 exactly this one cycle, even if
//               ex_stall=1. Shadow counter loaded with SHADOW_CYCLES.
//   SHADOW   -> counter decrements only when ex_stall=0; -> IDLE when counter
//               reaches 1 and ex_stall=0. ex_valid ignored throughout.
//  branch_target holds its last value when branch=0.
//  busy=1 in REDIRECT and SHADOW. Total blanked cycles with no stall =
//   1+SHADOW_CYCLES.
//  redirect_count increments on IDLE->REDIRECT and saturates at 2^CNT_W-1.
//  Not-taken branch: no output change except illegal_br as defined.
// STRUCTURE
//  riscv_pkg: funct3 constants (F3_BEQ..F3_BGEU), fsm state typedef
//   (IDLE/REDIRECT/SHADOW).
//  Sub-module: branch_cmp (combinational; rs1, rs2, funct3 -> taken, illegal).
//  Top module holds FSM, shadow counter, target adder, and output registers.
// TESTING
//  1 rst_n=0 mid-REDIRECT -> all outputs 0 immediately; after release
//    state=IDLE and redirect_count=0.
//  2 BEQ rs1=rs2=5, pc=0x100, imm=0x20 -> branch=1 for one cycle at N+1,
//    target=0x120; busy for 2 cycles; count=1.
//  3 BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands ->
//    not taken, branch stays 0.
//  4 JALR rs1=0x1003, imm=4 -> target=0x1006. is_jal and is_jalr both set ->
//    JALR target is used.
//  5 Taken branch, then ex_valid=1 with a taken JAL in the next 2 cycles ->
//    JAL ignored. ex_stall=1 during SHADOW -> busy extends by the number of
//    stalled cycles.
//  6 is_branch with funct3=010 -> illegal_br pulses once, branch=0. pc=0xFFFFFFF0,
//    imm=0x20 -> target=0x10. Force count to all-ones -> no wrap.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared branch-resolution definitions: RV32 branch funct3 encodings and the
// redirect FSM state type.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SHADOW   = 2'd2
    } br_state_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational RV32 branch condition evaluator: decides taken/not-taken from
// the two operands and funct3, flagging the reserved encodings 010/011.
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;

    assign rs1_s = rs1;
    assign rs2_s = rs2;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = (rs1_s < rs2_s);
            F3_BGE:  taken = (rs1_s >= rs2_s);
            F3_BLTU: taken = (rs1 < rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: registers a one-cycle redirect pulse with its
// target, then blanks resolution while the wrong-path shadow is flushed.
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int SHADOW_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    output logic             branch,
    output logic [XLEN-1:0]  branch_target,
    output logic             busy,
    output logic             illegal_br,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int SC_W = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);
    localparam logic [SC_W-1:0] SHADOW_LOAD = SC_W'(SHADOW_CYCLES);

    br_state_t        state_q;
    br_state_t        state_d;
    logic [SC_W-1:0]  shadow_cnt;

    logic             cmp_taken;
    logic             cmp_illegal;
    logic             resolve;
    logic             taken;
    logic             illegal_hit;
    logic             launch;
    logic [XLEN-1:0]  pc_target;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  next_target;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1     (rs1_data),
        .rs2     (rs2_data),
        .funct3  (funct3),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign resolve = (state_q == IDLE) && ex_valid && !ex_stall;

    // Jumps dominate a simultaneously flagged conditional branch, so a reserved
    // funct3 only counts as illegal when the instruction is a plain branch.
    assign taken       = is_jalr || is_jal || (is_branch && cmp_taken);
    assign illegal_hit = resolve && !is_jalr && !is_jal && is_branch && cmp_illegal;
    assign launch      = resolve && taken;

    assign pc_target   = pc + imm;
    assign jalr_sum    = rs1_data + imm;
    assign next_target = is_jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : pc_target;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (launch) state_d = REDIRECT;
            REDIRECT: state_d = SHADOW;
            SHADOW:   if (!ex_stall && (shadow_cnt == SC_W'(1))) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Shadow counter: armed while the redirect pulse is out, drained by unstalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_cnt <= '0;
        end else if (state_q == REDIRECT) begin
            shadow_cnt <= SHADOW_LOAD;
        end else if ((state_q == SHADOW) && !ex_stall && (shadow_cnt != '0)) begin
            shadow_cnt <= shadow_cnt - SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch         <= 1'b0;
            branch_target  <= '0;
            illegal_br     <= 1'b0;
            redirect_count <= '0;
        end else begin
            branch     <= launch;
            illegal_br <= illegal_hit;
            if (launch) begin
                branch_target <= next_target;
                if (redirect_count != {CNT_W{1'b1}})
                    redirect_count <= redirect_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit plus hand sequences for
// reset, shadow blanking, stall extension and counter saturation.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_stall;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        branch;
    logic [31:0] branch_target;
    logic        busy;
    logic        illegal_br;
    logic [3:0]  redirect_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_tgt;
    logic [3:0]  cnt_exp;

    branch_resolve_unit #(.XLEN(32), .SHADOW_CYCLES(1), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .funct3         (funct3),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .pc             (pc),
        .imm            (imm),
        .branch         (branch),
        .branch_target  (branch_target),
        .busy           (busy),
        .illegal_br     (illegal_br),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        exp_taken;
        logic        exp_ill;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        is_branch = v.br;
        is_jal    = v.jal;
        is_jalr   = v.jalr;
        funct3    = v.f3;
        rs1_data  = v.rs1;
        rs2_data  = v.rs2;
        pc        = v.pc;
        imm       = v.imm;
    endtask

    task automatic count_up();
        if (cnt_exp != 4'hF) cnt_exp = cnt_exp + 4'd1;
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        drive(v);
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        if (v.exp_taken) begin
            last_tgt = v.exp_tgt;
            count_up();
        end
        check($sformatf("v%0d branch", idx), 32'(branch), 32'(v.exp_taken));
        check($sformatf("v%0d target", idx), branch_target, last_tgt);
        check($sformatf("v%0d illegal", idx), 32'(illegal_br), 32'(v.exp_ill));
        check($sformatf("v%0d busy1", idx), 32'(busy), 32'(v.exp_taken));
        @(negedge clk);
        check($sformatf("v%0d branch_off", idx), 32'(branch), 32'd0);
        check($sformatf("v%0d illegal_off", idx), 32'(illegal_br), 32'd0);
        check($sformatf("v%0d busy2", idx), 32'(busy), 32'(v.exp_taken));
        @(negedge clk);
        check($sformatf("v%0d busy3", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d count", idx), 32'(redirect_count), 32'(cnt_exp));
    endtask

    initial begin
        //            br    jal   jalr  f3      rs1           rs2           pc            imm           tk    ill   tgt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'd5,        32'd5,        32'h100,      32'h20,       1'b1, 1'b0, 32'h120};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b001, 32'd5,        32'd5,        32'h100,      32'h20,       1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h10,       1'b1, 1'b0, 32'h210};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h10,       1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'b101, 32'd1,        32'hFFFFFFFF, 32'h300,      32'hFFFFFFFC, 1'b1, 1'b0, 32'h2FC};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b111, 32'd1,        32'hFFFFFFFF, 32'h300,      32'h4,        1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h1003,     32'd0,        32'h500,      32'h4,        1'b1, 1'b0, 32'h1006};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'b000, 32'h2000,     32'd0,        32'h40,       32'h11,       1'b1, 1'b0, 32'h2010};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h2000,     32'd0,        32'h40,       32'h100,      1'b1, 1'b0, 32'h140};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'd7,        32'd7,        32'hFFFFFFF0, 32'h20,       1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'd7,        32'd7,        32'hFFFFFFF0, 32'h20,       1'b1, 1'b0, 32'h10};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'b000, 32'd7,        32'd7,        32'h700,      32'h20,       1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b001, 32'd3,        32'd4,        32'h80,       32'h8,        1'b1, 1'b0, 32'h88};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 3'b011, 32'd3,        32'd4,        32'h80,       32'h8,        1'b0, 1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 3'b110, 32'd1,        32'd2,        32'h0,        32'h8,        1'b1, 1'b0, 32'h8};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 3'b111, 32'd2,        32'd2,        32'h10,       32'h10,       1'b1, 1'b0, 32'h20};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 3'b010, 32'd0,        32'd0,        32'h60,       32'h4,        1'b1, 1'b0, 32'h64};

        rst_n = 1'b0; ex_valid = 1'b0; ex_stall = 1'b0;
        is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; funct3 = 3'b000;
        rs1_data = '0; rs2_data = '0; pc = '0; imm = '0;
        cnt_exp = 4'd0; last_tgt = 32'd0;

        // Reset state, then abort a redirect mid-pulse.
        #12;
        check("rst branch", 32'(branch), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(redirect_count), 32'd0);
        check("rst target", branch_target, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(vecs[0]);
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        check("pre-abort branch", 32'(branch), 32'd1);
        check("pre-abort count", 32'(redirect_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort branch", 32'(branch), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort target", branch_target, 32'd0);
        check("abort illegal", 32'(illegal_br), 32'd0);
        check("abort count", 32'(redirect_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-abort busy", 32'(busy), 32'd0);
        check("post-abort branch", 32'(branch), 32'd0);
        check("post-abort count", 32'(redirect_count), 32'd0);

        for (int i = 0; i < 17; i++) apply_vec(i);

        // Taken JAL presented during REDIRECT and SHADOW must be ignored.
        @(negedge clk);
        is_branch = 1'b1; is_jal = 1'b0; is_jalr = 1'b0; funct3 = 3'b000;
        rs1_data = 32'd9; rs2_data = 32'd9; pc = 32'h400; imm = 32'h40;
        ex_valid = 1'b1;
        @(negedge clk);
        is_branch = 1'b0; is_jal = 1'b1; pc = 32'h0; imm = 32'h800;
        count_up();
        check("shadow branch", 32'(branch), 32'd1);
        check("shadow target", branch_target, 32'h440);
        @(negedge clk);
        check("shadow branch_off", 32'(branch), 32'd0);
        check("shadow busy", 32'(busy), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        check("shadow idle", 32'(busy), 32'd0);
        check("shadow jal ignored branch", 32'(branch), 32'd0);
        check("shadow jal ignored target", branch_target, 32'h440);
        check("shadow count", 32'(redirect_count), 32'(cnt_exp));

        // Stall for two SHADOW cycles: busy lasts 2 + 2 cycles, pulse still one cycle.
        @(negedge clk);
        is_branch = 1'b0; is_jal = 1'b1; pc = 32'h600; imm = 32'h0;
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; ex_stall = 1'b1;
        count_up();
        check("stall branch", 32'(branch), 32'd1);
        check("stall target", branch_target, 32'h600);
        @(negedge clk);
        check("stall branch_off", 32'(branch), 32'd0);
        check("stall busy2", 32'(busy), 32'd1);
        @(negedge clk);
        check("stall busy3", 32'(busy), 32'd1);
        @(negedge clk);
        ex_stall = 1'b0;
        check("stall busy4", 32'(busy), 32'd1);
        @(negedge clk);
        check("stall busy5", 32'(busy), 32'd0);
        check("stall count", 32'(redirect_count), 32'(cnt_exp));

        // Drive the 4-bit counter past all-ones; it must stick at 15.
        for (int i = 0; i < 4; i++) apply_vec(8);
        check("sat count", 32'(redirect_count), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
